// File: rtl/booth_mul_pkg.sv
// Shared types for the round-robin Booth multiplier block.
// Holds the operand and product widths, the FSM encoding and the captured-operand struct.
package booth_mul_pkg;

  localparam int OP_W = 16;

  typedef logic signed [OP_W-1:0]   operand_t;
  typedef logic signed [2*OP_W-1:0] product_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    OUT  = 2'd2
  } state_t;

  typedef struct packed {
    operand_t a;
    operand_t b;
  } op_t;

endpackage

// File: rtl/booth_mul_arbiter_rr_arbiter.sv
// Round-robin pick: first asserted req starting at ptr and wrapping; purely combinational.
// No state and no backpressure; the caller owns the pointer update.
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_idx,
  output logic           any
);

  localparam int SW = IDW + 1;

  logic [IDW-1:0] cand [N];

  // cand[k] is the requester inspected k-th, i.e. (ptr + k) mod N.
  for (genvar k = 0; k < N; k++) begin : g_cand
    logic [SW-1:0] sum;
    assign sum     = {1'b0, ptr} + SW'(k);
    assign cand[k] = (sum >= SW'(N)) ? IDW'(sum - SW'(N)) : sum[IDW-1:0];
  end

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[cand[k]]) begin
        grant           = '0;
        grant[cand[k]]  = 1'b1;
        grant_idx       = cand[k];
        any             = 1'b1;
      end
    end
  end

endmodule

// File: rtl/boothmul.sv
// Combinational radix-4 Booth multiplier, signed 16x16 -> 32, full precision.
// Zero latency and no flow control; the caller budgets the path as a multicycle.
module boothmul
  import booth_mul_pkg::*;
(
  input  operand_t a,
  input  operand_t b,
  output product_t p
);

  localparam int NPP = OP_W / 2;

  logic [OP_W:0] bx;
  product_t      ax;
  product_t      pp [NPP];

  assign bx = {b, 1'b0};
  assign ax = {{OP_W{a[OP_W-1]}}, a};

  // Each overlapping 3-bit group of b selects 0, +-a or +-2a.
  always_comb begin
    for (int i = 0; i < NPP; i++) begin
      case (bx[2*i +: 3])
        3'b001, 3'b010: pp[i] = ax;
        3'b011:         pp[i] = ax <<< 1;
        3'b100:         pp[i] = -(ax <<< 1);
        3'b101, 3'b110: pp[i] = -ax;
        default:        pp[i] = '0;
      endcase
    end
  end

  always_comb begin
    p = '0;
    for (int i = 0; i < NPP; i++) begin
      p = p + (pp[i] <<< (2*i));
    end
  end

endmodule

// File: rtl/booth_mul_arbiter.sv
// Shares one Booth multiplier among N_REQ requesters round-robin; accept-to-rsp_valid is MUL_WAIT+1 cycles.
// Only accepts in IDLE; rsp_ready low parks the block in OUT with the response held stable.
module booth_mul_arbiter
  import booth_mul_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int ID_W     = $clog2(N_REQ),
  parameter int MUL_WAIT = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [OP_W*N_REQ-1:0] req_a,
  input  logic [OP_W*N_REQ-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           rsp_prod,
  output logic                  busy
);

  localparam int               CNT_W    = (MUL_WAIT > 1) ? $clog2(MUL_WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_WAIT - 1);

  state_t           state;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  op_id;
  logic [CNT_W-1:0] cnt;
  op_t              op;

  logic [N_REQ-1:0] win_oh;
  logic [ID_W-1:0]  win_idx;
  logic [ID_W-1:0]  next_ptr;
  logic             win_any;
  op_t              win_op;
  product_t         prod;

  rr_arbiter #(
    .N   (N_REQ),
    .IDW (ID_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (win_oh),
    .grant_idx (win_idx),
    .any       (win_any)
  );

  assign win_op.a = req_a[win_idx*OP_W +: OP_W];
  assign win_op.b = req_b[win_idx*OP_W +: OP_W];
  assign next_ptr = (win_idx == ID_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;

  assign req_ready = (state == IDLE) ? win_oh : '0;
  assign busy      = (state != IDLE);

  // op is only written in IDLE, so the multiplier inputs are frozen for all of MUL.
  boothmul u_mul (
    .a (op.a),
    .b (op.b),
    .p (prod)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      op        <= '0;
      op_id     <= '0;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_prod  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_any) begin
            op     <= win_op;
            op_id  <= win_idx;
            rr_ptr <= next_ptr;
            cnt    <= CNT_INIT;
            state  <= MUL;
          end
        end
        MUL: begin
          if (cnt == '0) begin
            rsp_prod  <= prod;
            rsp_id    <= op_id;
            rsp_valid <= 1'b1;
            state     <= OUT;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        OUT: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/booth_mul_arbiter.md
Name: booth_mul_arbiter

Overview:
- Shares one combinational 16x16 signed Booth multiplier (boothmul) between N_REQ requesters, e.g. audio channels or filter taps needing occasional products.
- Arbitrates round-robin and registers the winner's operands.
- Treats the multiplier as a multicycle path of MUL_WAIT cycles, then returns the registered 32-bit product on a single response channel tagged with the requester index.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- ID_W, $clog2(N_REQ), width of the requester tag.
- MUL_WAIT, 2, cycles allotted to the multiplier path (>=1).

Ports:
- clk  in  1  single clock.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  N_REQ  per-requester operand valid.
- req_ready  out  N_REQ  per-requester accept, at most one bit high.
- req_a  in  16*N_REQ  signed multiplicand, requester i at [16i+15:16i].
- req_b  in  16*N_REQ  signed multiplier, same packing.
- rsp_valid  out  1  product available.
- rsp_ready  in  1  consumer accepts product.
- rsp_id  out  ID_W  index of requester that owns rsp_prod.
- rsp_prod  out  32  signed product a*b.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n low at a clk edge): state=IDLE, rr_ptr=0, rsp_valid=0, rsp_id=0, rsp_prod=0, busy=0, op regs=0, wait counter=0.
- Reset overrides everything: an in-flight op is discarded and a pending response is dropped, with no rsp_valid pulse.
- req_ready is combinational from req_valid and state. It is nonzero only in IDLE and only for the winner.
- States:
  - IDLE: winner = first i with req_valid[i] searching rr_ptr, rr_ptr+1, ... wrapping mod N_REQ. If any valid: req_ready[winner]=1 (handshake this cycle), capture a/b/id into op regs, rr_ptr <= (winner+1) mod N_REQ, cnt <= MUL_WAIT-1, go MUL. If none valid: stay IDLE, rr_ptr unchanged.
  - MUL: op regs drive boothmul. If cnt==0: rsp_prod <= product, rsp_id <= op id, rsp_valid <= 1, go OUT. Otherwise cnt <= cnt-1.
  - OUT: hold rsp_valid, rsp_id and rsp_prod stable. On rsp_valid&&rsp_ready: rsp_valid <= 0, go IDLE. No new request is accepted in the same cycle.
- Latency: request handshake in cycle T gives rsp_valid high in cycle T+MUL_WAIT+1. With MUL_WAIT=2: accept in cycle 0, rsp_valid in cycle 3.
- Minimum issue interval is MUL_WAIT+2 cycles when rsp_ready is held high.
- Arithmetic:
  - Full-precision signed 16x16 to 32, two's complement, no saturation or rounding.
  - -32768*-32768 = 0x4000_0000.
- Constraints: op regs hold the multicycle source. Implementation must keep op regs stable for the entire MUL state; STA treats the boothmul path as MUL_WAIT cycles.
- Boundary cases:
  - All N_REQ valid simultaneously: strict rotation, each served once before any repeats.
  - A single requester valid continuously: served back-to-back at the minimum interval.
  - req_valid dropped before grant: no effect; the requester has no obligation to hold.
  - req_valid and operand changes while not granted: ignored.
  - rsp_ready high outside OUT: ignored.
  - rsp_ready held low: the block stalls in OUT indefinitely, req_ready stays all-zero, and no data is lost.
  - rr_ptr wrap: a grant to N_REQ-1 sets rr_ptr=0.

Decomposition:
- Package booth_mul_pkg:
  - typedef operand_t = logic signed [15:0].
  - typedef product_t = logic signed [31:0].
  - enum state_t {IDLE, MUL, OUT}.
  - constant OP_W=16.
- Sub-module rr_arbiter #(N):
  - Inputs: req, ptr.
  - Outputs: grant one-hot, grant_idx, any.
  - Purely combinational.
- boothmul is instantiated unchanged as the datapath.

Test Plan:
- Single op: req 0 sends a=3, b=-5 at cycle 0 with rsp_ready=1 -> rsp_valid in cycle 3, rsp_prod=-15 (0xFFFF_FFF1), rsp_id=0, then back in IDLE.
- Extremes: a=-32768, b=-32768 -> 0x4000_0000. a=32767, b=-32768 -> 0xC000_8000. a=0, b=-1 -> 0.
- Round-robin: after reset, all 4 valid continuously -> grants in order 0,1,2,3,0. Then with only req 0 and req 2 valid after a grant to 0 -> next grant goes to 2.
- Backpressure: rsp_ready low for 10 cycles after rsp_valid -> rsp_prod and rsp_id stay stable, req_ready stays 0000, and a waiting req 1 is granted only in the cycle after rsp_ready goes high.
- Reset mid-op: rst_n low for 1 cycle during MUL -> outputs at reset values, no response for that op. The next request from req 0 is served normally, with rr_ptr restarted at 0.
- Random soak: 10k random operands and valids with random rsp_ready, MUL_WAIT in {1,3} -> every product matches the a*b reference model, IDs match, and no request is lost or duplicated.
